// File: rtl/lift_pkg.sv
// Shared types and constants for the lift car controller: state and direction
// encodings, floor code width and the valid-floor mask helper.
package lift_pkg;

   localparam int FLOOR_W    = 3;
   localparam int MAX_FLOORS = 8;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_MOVE_UP   = 2'd1,
      ST_MOVE_DOWN = 2'd2,
      ST_DOOR_OPEN = 2'd3
   } lift_state_e;

   typedef enum logic {
      DIR_UP   = 1'b0,
      DIR_DOWN = 1'b1
   } lift_dir_e;

   // One bit per served floor; call bits outside this mask are never latched.
   function automatic logic [MAX_FLOORS-1:0] valid_mask(input int num_floors);
      logic [MAX_FLOORS-1:0] m;
      for (int f = 0; f < MAX_FLOORS; f++) begin
         m[f] = (f < num_floors);
      end
      return m;
   endfunction

endpackage

// File: rtl/lift_call_scanner.sv
// Combinational call scanner: reports whether a call exists at, above or
// below the given floor.
module lift_call_scanner
   import lift_pkg::*;
(
   input  logic [MAX_FLOORS-1:0] i_req,
   input  logic [FLOOR_W-1:0]    i_floor,
   output logic                  o_hit,
   output logic                  o_above,
   output logic                  o_below
);

   logic [MAX_FLOORS-1:0] w_above_bits;
   logic [MAX_FLOORS-1:0] w_below_bits;

   genvar gi;
   generate
      for (gi = 0; gi < MAX_FLOORS; gi++) begin : g_cmp
         assign w_above_bits[gi] = i_req[gi] & (FLOOR_W'(gi) > i_floor);
         assign w_below_bits[gi] = i_req[gi] & (FLOOR_W'(gi) < i_floor);
      end
   endgenerate

   assign o_hit   = i_req[i_floor];
   assign o_above = |w_above_bits;
   assign o_below = |w_below_bits;

endmodule

// File: rtl/lift_floor_controller.sv
// Lift car controller: latches floor calls, sweeps the car up/down one floor
// at a time and holds the door open for a fixed time at each served floor.
module lift_floor_controller
   import lift_pkg::*;
#(
   parameter int NUM_FLOORS  = 8,
   parameter int MOVE_CYCLES = 4,
   parameter int DOOR_CYCLES = 6
)(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [MAX_FLOORS-1:0] call_req,
   output logic [FLOOR_W-1:0]    floor,
   output logic                  moving_up,
   output logic                  moving_down,
   output logic                  door_open,
   output logic [MAX_FLOORS-1:0] pending
);

   localparam logic [MAX_FLOORS-1:0] VALID_MASK = valid_mask(NUM_FLOORS);
   localparam int MOVE_W = (MOVE_CYCLES > 1) ? $clog2(MOVE_CYCLES) : 1;
   localparam int DOOR_W = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
   localparam logic [MOVE_W-1:0] MOVE_LAST = MOVE_W'(MOVE_CYCLES - 1);
   localparam logic [DOOR_W-1:0] DOOR_LAST = DOOR_W'(DOOR_CYCLES - 1);

   lift_state_e           r_state;
   logic [FLOOR_W-1:0]    r_floor;
   logic [MAX_FLOORS-1:0] r_pending;
   lift_dir_e             r_last_dir;
   logic [MOVE_W-1:0]     r_move_cnt;
   logic [DOOR_W-1:0]     r_door_cnt;

   lift_state_e           w_state_next;
   logic [FLOOR_W-1:0]    w_floor_next;
   logic [MAX_FLOORS-1:0] w_pending_next;
   lift_dir_e             w_dir_next;
   logic [MOVE_W-1:0]     w_move_cnt_next;
   logic [DOOR_W-1:0]     w_door_cnt_next;

   logic [MAX_FLOORS-1:0] w_req_in;
   logic [MAX_FLOORS-1:0] w_scan_req;
   logic                  w_arrive;
   logic [FLOOR_W-1:0]    w_step_floor;
   logic [FLOOR_W-1:0]    w_scan_floor;
   logic                  w_hit;
   logic                  w_above;
   logic                  w_below;

   assign w_req_in     = call_req & VALID_MASK;
   assign w_scan_req   = r_pending | w_req_in;
   assign w_arrive     = ((r_state == ST_MOVE_UP) || (r_state == ST_MOVE_DOWN)) &&
                         (r_move_cnt == MOVE_LAST);
   assign w_step_floor = (r_state == ST_MOVE_UP) ? r_floor + FLOOR_W'(1)
                                                 : r_floor - FLOOR_W'(1);
   // On the arrival edge the stop/continue decision is made for the new floor.
   assign w_scan_floor = w_arrive ? w_step_floor : r_floor;

   lift_call_scanner u_scanner (
      .i_req   (w_scan_req),
      .i_floor (w_scan_floor),
      .o_hit   (w_hit),
      .o_above (w_above),
      .o_below (w_below)
   );

   always_comb begin
      w_state_next    = r_state;
      w_floor_next    = r_floor;
      w_pending_next  = w_scan_req;
      w_dir_next      = r_last_dir;
      w_move_cnt_next = r_move_cnt;
      w_door_cnt_next = r_door_cnt;
      case (r_state)
         ST_IDLE: begin
            w_move_cnt_next = '0;
            w_door_cnt_next = '0;
            if (w_hit) begin
               w_state_next            = ST_DOOR_OPEN;
               w_pending_next[r_floor] = 1'b0;
            end else if (r_last_dir == DIR_UP && w_above) begin
               w_state_next = ST_MOVE_UP;
            end else if (r_last_dir == DIR_DOWN && w_below) begin
               w_state_next = ST_MOVE_DOWN;
            end else if (w_above) begin
               w_state_next = ST_MOVE_UP;
               w_dir_next   = DIR_UP;
            end else if (w_below) begin
               w_state_next = ST_MOVE_DOWN;
               w_dir_next   = DIR_DOWN;
            end
         end
         ST_MOVE_UP, ST_MOVE_DOWN: begin
            if (w_arrive) begin
               w_floor_next    = w_step_floor;
               w_move_cnt_next = '0;
               if (w_hit) begin
                  w_state_next                 = ST_DOOR_OPEN;
                  w_pending_next[w_step_floor] = 1'b0;
                  w_door_cnt_next              = '0;
               end else if (!((r_state == ST_MOVE_UP && w_above) ||
                              (r_state == ST_MOVE_DOWN && w_below))) begin
                  w_state_next = ST_IDLE;
               end
            end else begin
               w_move_cnt_next = r_move_cnt + MOVE_W'(1);
            end
         end
         ST_DOOR_OPEN: begin
            // A call for the open floor is absorbed by keeping the door open longer.
            w_pending_next[r_floor] = 1'b0;
            if (w_hit) begin
               w_door_cnt_next = '0;
            end else if (r_door_cnt == DOOR_LAST) begin
               w_state_next    = ST_IDLE;
               w_door_cnt_next = '0;
            end else begin
               w_door_cnt_next = r_door_cnt + DOOR_W'(1);
            end
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_IDLE;
         r_floor    <= '0;
         r_pending  <= '0;
         r_last_dir <= DIR_UP;
         r_move_cnt <= '0;
         r_door_cnt <= '0;
      end else begin
         r_state    <= w_state_next;
         r_floor    <= w_floor_next;
         r_pending  <= w_pending_next;
         r_last_dir <= w_dir_next;
         r_move_cnt <= w_move_cnt_next;
         r_door_cnt <= w_door_cnt_next;
      end
   end

   assign floor       = r_floor;
   assign pending     = r_pending;
   assign moving_up   = (r_state == ST_MOVE_UP);
   assign moving_down = (r_state == ST_MOVE_DOWN);
   assign door_open   = (r_state == ST_DOOR_OPEN);

endmodule
